// File: rtl/init_port.sv
// rtl/init_port.sv - initiator-side serial bus port: arbitration, capture, serial shift-out, read deserialise, split handling
module init_port #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_req,
    input  logic [ADDR_WIDTH-1:0] init_addr_in,
    input  logic                  init_addr_in_valid,
    input  logic [DATA_WIDTH-1:0] init_data_in,
    input  logic                  init_data_in_valid,
    input  logic                  init_rw,
    output logic                  init_grant,
    output logic                  init_ack,
    output logic                  init_split_ack,
    output logic [DATA_WIDTH-1:0] init_data_out,
    output logic                  init_data_out_valid,
    output logic                  bus_req,
    input  logic                  bus_grant,
    output logic                  bus_addr_out,
    output logic                  bus_addr_valid,
    output logic                  bus_data_out,
    output logic                  bus_data_out_valid,
    output logic                  bus_mode,
    input  logic                  bus_data_in,
    input  logic                  bus_data_in_valid,
    input  logic                  bus_ack,
    input  logic                  bus_split_ack
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW) + 1;
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_REQ      = 4'd1;
    localparam logic [3:0] S_CAPTURE  = 4'd2;
    localparam logic [3:0] S_ADDR     = 4'd3;
    localparam logic [3:0] S_WDATA    = 4'd4;
    localparam logic [3:0] S_WAIT_ACK = 4'd5;
    localparam logic [3:0] S_RDATA    = 4'd6;
    localparam logic [3:0] S_SPLIT    = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    logic [3:0]            state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [DATA_WIDTH-1:0] data_sr;
    logic [DATA_WIDTH-1:0] rdata_sr;
    logic                  rw_q;
    logic                  addr_have;
    logic                  data_have;

    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  rw_nxt;
    logic                  addr_have_nxt;
    logic                  data_have_nxt;
    logic                  cap_done;
    logic [DATA_WIDTH-1:0] rdata_shift;

    // Capture looks through this cycle's valids so a same-cycle arrival completes immediately
    always_comb begin
        addr_nxt      = init_addr_in_valid ? init_addr_in : addr_sr;
        rw_nxt        = init_addr_in_valid ? init_rw : rw_q;
        data_nxt      = init_data_in_valid ? init_data_in : data_sr;
        addr_have_nxt = addr_have | init_addr_in_valid;
        data_have_nxt = data_have | init_data_in_valid;
        cap_done      = addr_have_nxt && (!rw_nxt || data_have_nxt);
        rdata_shift   = {bus_data_in, rdata_sr[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            addr_sr             <= '0;
            data_sr             <= '0;
            rdata_sr            <= '0;
            rw_q                <= 1'b0;
            addr_have           <= 1'b0;
            data_have           <= 1'b0;
            init_grant          <= 1'b0;
            init_ack            <= 1'b0;
            init_split_ack      <= 1'b0;
            init_data_out       <= '0;
            init_data_out_valid <= 1'b0;
            bus_req             <= 1'b0;
            bus_addr_out        <= 1'b0;
            bus_addr_valid      <= 1'b0;
            bus_data_out        <= 1'b0;
            bus_data_out_valid  <= 1'b0;
            bus_mode            <= 1'b0;
        end else begin
            init_ack            <= 1'b0;
            init_split_ack      <= 1'b0;
            init_data_out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (init_req) begin
                        bus_req <= 1'b1;
                        cnt     <= '0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!init_req) begin
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        state   <= S_IDLE;
                    end else if (bus_grant) begin
                        init_grant <= 1'b1;
                        addr_have  <= 1'b0;
                        data_have  <= 1'b0;
                        cnt        <= '0;
                        state      <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    addr_sr   <= addr_nxt;
                    data_sr   <= data_nxt;
                    rw_q      <= rw_nxt;
                    addr_have <= addr_have_nxt;
                    data_have <= data_have_nxt;
                    if (cap_done) begin
                        init_grant     <= 1'b0;
                        cnt            <= '0;
                        bus_mode       <= rw_nxt;
                        bus_addr_valid <= 1'b1;
                        bus_addr_out   <= addr_nxt[0];
                        addr_sr        <= addr_nxt >> 1;
                        state          <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (cnt == ADDR_LAST) begin
                        bus_addr_valid <= 1'b0;
                        bus_addr_out   <= 1'b0;
                        cnt            <= '0;
                        if (rw_q) begin
                            bus_data_out_valid <= 1'b1;
                            bus_data_out       <= data_sr[0];
                            data_sr            <= data_sr >> 1;
                            state              <= S_WDATA;
                        end else begin
                            state <= S_RDATA;
                        end
                    end else begin
                        cnt          <= cnt + CW'(1);
                        bus_addr_out <= addr_sr[0];
                        addr_sr      <= addr_sr >> 1;
                    end
                end
                S_WDATA: begin
                    if (cnt == DATA_LAST) begin
                        bus_data_out_valid <= 1'b0;
                        bus_data_out       <= 1'b0;
                        cnt                <= '0;
                        state              <= S_WAIT_ACK;
                    end else begin
                        cnt          <= cnt + CW'(1);
                        bus_data_out <= data_sr[0];
                        data_sr      <= data_sr >> 1;
                    end
                end
                S_WAIT_ACK: begin
                    if (bus_ack) begin
                        init_ack <= 1'b1;
                        bus_req  <= 1'b0;
                        bus_mode <= 1'b0;
                        cnt      <= '0;
                        state    <= S_DONE;
                    end
                end
                S_RDATA: begin
                    // A split is honoured only before the first bit; a colliding bit is dropped
                    if (bus_split_ack && cnt == '0) begin
                        init_split_ack <= 1'b1;
                        bus_req        <= 1'b0;
                        cnt            <= '0;
                        state          <= S_SPLIT;
                    end else if (bus_data_in_valid) begin
                        rdata_sr <= rdata_shift;
                        if (cnt == DATA_LAST) begin
                            init_data_out       <= rdata_shift;
                            init_data_out_valid <= 1'b1;
                            init_ack            <= 1'b1;
                            bus_req             <= 1'b0;
                            bus_mode            <= 1'b0;
                            cnt                 <= '0;
                            state               <= S_DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_SPLIT: begin
                    if (bus_grant) begin
                        bus_req <= 1'b1;
                        cnt     <= '0;
                        state   <= S_RDATA;
                    end
                end
                S_DONE: begin
                    if (!init_req) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_init_port.sv
// tb/tb_init_port.sv - table-driven scoreboard bench for init_port
module tb_init_port;

    localparam int AW = 16;
    localparam int DW = 8;

    localparam int W_BUSREQ = 0;
    localparam int W_GRANT  = 1;
    localparam int W_AV_LO  = 2;
    localparam int W_DOV_HI = 3;
    localparam int W_DOV_LO = 4;
    localparam int W_ACK    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_req;
    logic [AW-1:0] init_addr_in;
    logic          init_addr_in_valid;
    logic [DW-1:0] init_data_in;
    logic          init_data_in_valid;
    logic          init_rw;
    logic          init_grant;
    logic          init_ack;
    logic          init_split_ack;
    logic [DW-1:0] init_data_out;
    logic          init_data_out_valid;
    logic          bus_req;
    logic          bus_grant;
    logic          bus_addr_out;
    logic          bus_addr_valid;
    logic          bus_data_out;
    logic          bus_data_out_valid;
    logic          bus_mode;
    logic          bus_data_in;
    logic          bus_data_in_valid;
    logic          bus_ack;
    logic          bus_split_ack;

    always #5 clk = ~clk;

    init_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_req            (init_req),
        .init_addr_in        (init_addr_in),
        .init_addr_in_valid  (init_addr_in_valid),
        .init_data_in        (init_data_in),
        .init_data_in_valid  (init_data_in_valid),
        .init_rw             (init_rw),
        .init_grant          (init_grant),
        .init_ack            (init_ack),
        .init_split_ack      (init_split_ack),
        .init_data_out       (init_data_out),
        .init_data_out_valid (init_data_out_valid),
        .bus_req             (bus_req),
        .bus_grant           (bus_grant),
        .bus_addr_out        (bus_addr_out),
        .bus_addr_valid      (bus_addr_valid),
        .bus_data_out        (bus_data_out),
        .bus_data_out_valid  (bus_data_out_valid),
        .bus_mode            (bus_mode),
        .bus_data_in         (bus_data_in),
        .bus_data_in_valid   (bus_data_in_valid),
        .bus_ack             (bus_ack),
        .bus_split_ack       (bus_split_ack)
    );

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            split;
        int            ack_delay;
        logic [DW-1:0] exp_data;
        int            exp_splits;
    } vec_t;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            splits;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    int n_vec = 0;
    int n_err = 0;

    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_data = '0;
    int            abits = 0;
    int            dbits = 0;
    int            split_seen = 0;
    logic          mode_cap = 1'b0;
    logic          prev_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit sel(input int which);
        case (which)
            W_BUSREQ: return bus_req;
            W_GRANT:  return init_grant;
            W_AV_LO:  return !bus_addr_valid;
            W_DOV_HI: return bus_data_out_valid;
            W_DOV_LO: return !bus_data_out_valid;
            default:  return init_ack;
        endcase
    endfunction

    task automatic wait_until(input int which, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            if (sel(which)) return;
            @(negedge clk);
        end
        n_vec++;
        n_err++;
        $display("FAIL timeout_%s: condition not reached in %0d cycles", name, limit);
    endtask

    // Monitor: reassembles serial traffic and scores each completion against the queue head
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus_addr_valid) begin
                if (abits < AW) acc_addr[abits] = bus_addr_out;
                abits++;
                mode_cap = bus_mode;
            end
            if (bus_data_out_valid) begin
                if (dbits < DW) acc_data[dbits] = bus_data_out;
                dbits++;
            end
            if (init_data_out_valid) check("valid_with_ack", init_ack, 1);
            if (init_split_ack) begin
                check("split_bus_req", bus_req, 0);
                split_seen++;
            end
            if (init_ack) begin
                check("ack_pulse_width", prev_ack, 0);
                check("ack_bus_req", bus_req, 0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: ack with empty scoreboard at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("addr_serial", acc_addr, e.addr);
                    check("addr_bits", abits, AW);
                    check("bus_mode", mode_cap, e.rw);
                    check("split_count", split_seen, e.splits);
                    if (e.rw) begin
                        check("wdata_serial", acc_data, e.data);
                        check("wdata_bits", dbits, DW);
                        check("wr_no_rvalid", init_data_out_valid, 0);
                    end else begin
                        check("rdata_out", init_data_out, e.data);
                        check("rdata_valid", init_data_out_valid, 1);
                        check("rd_no_wbits", dbits, 0);
                    end
                end
                abits = 0;
                dbits = 0;
                split_seen = 0;
                acc_addr = '0;
                acc_data = '0;
            end
            prev_ack = init_ack;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            abits = 0;
            dbits = 0;
            split_seen = 0;
            acc_addr = '0;
            acc_data = '0;
            prev_ack = 1'b0;
        end
    end

    task automatic arb_and_capture(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        @(negedge clk);
        init_req = 1'b1;
        wait_until(W_BUSREQ, 10, "bus_req");
        bus_grant = 1'b1;
        wait_until(W_GRANT, 10, "init_grant");
        bus_grant          = 1'b0;
        init_addr_in       = addr;
        init_rw            = rw;
        init_addr_in_valid = 1'b1;
        @(negedge clk);
        init_addr_in_valid = 1'b0;
        init_addr_in       = '0;
        if (rw) begin
            init_data_in       = wdata;
            init_data_in_valid = 1'b1;
            @(negedge clk);
            init_data_in_valid = 1'b0;
            init_data_in       = '0;
        end
        check("grant_dropped", init_grant, 0);
        check("addr_phase_start", bus_addr_valid, 1);
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e;
        e.rw     = v.rw;
        e.addr   = v.addr;
        e.data   = v.exp_data;
        e.splits = v.exp_splits;
        sb.push_back(e);
        arb_and_capture(v.rw, v.addr, v.wdata);
        if (v.rw) begin
            wait_until(W_DOV_HI, 40, "wdata_start");
            wait_until(W_DOV_LO, 20, "wdata_end");
            repeat (v.ack_delay - 1) @(negedge clk);
            bus_ack = 1'b1;
            @(negedge clk);
            bus_ack = 1'b0;
        end else begin
            wait_until(W_AV_LO, 40, "addr_end");
            if (v.split) begin
                bus_split_ack     = 1'b1;
                bus_data_in       = 1'b1;
                bus_data_in_valid = 1'b1;
                @(negedge clk);
                bus_split_ack     = 1'b0;
                bus_data_in_valid = 1'b0;
                repeat (3) @(negedge clk);
                bus_grant = 1'b1;
                @(negedge clk);
                bus_grant = 1'b0;
            end
            for (int i = 0; i < DW; i++) begin
                bus_data_in       = v.rdata[i];
                bus_data_in_valid = 1'b1;
                bus_split_ack     = (!v.split && i == 1);
                @(negedge clk);
                bus_split_ack = 1'b0;
                if (i == 3) begin
                    bus_data_in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            bus_data_in_valid = 1'b0;
            bus_data_in       = 1'b0;
        end
        wait_until(W_ACK, 60, "init_ack");
        init_req = 1'b0;
    endtask

    function automatic logic [31:0] all_outputs();
        return {14'd0, init_grant, init_ack, init_split_ack, init_data_out, init_data_out_valid,
                bus_req, bus_addr_out, bus_addr_valid, bus_data_out, bus_data_out_valid, bus_mode};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 16'h0012, 8'hAA, 8'h00, 1'b0, 3, 8'hAA, 0};
        vecs[1] = '{1'b0, 16'h0034, 8'h00, 8'h5C, 1'b0, 1, 8'h5C, 0};
        vecs[2] = '{1'b0, 16'h0056, 8'h00, 8'h3C, 1'b1, 1, 8'h3C, 1};
        vecs[3] = '{1'b1, 16'h1234, 8'hAB, 8'h00, 1'b0, 2, 8'hAB, 0};
        vecs[4] = '{1'b0, 16'h00F0, 8'h00, 8'h81, 1'b0, 1, 8'h81, 0};
        vecs[5] = '{1'b1, 16'hFFFF, 8'h00, 8'h00, 1'b0, 1, 8'h00, 0};
        vecs[6] = '{1'b0, 16'h8001, 8'h00, 8'hFF, 1'b0, 1, 8'hFF, 0};

        rst                = 1'b1;
        init_req           = 1'b0;
        init_addr_in       = '0;
        init_addr_in_valid = 1'b0;
        init_data_in       = '0;
        init_data_in_valid = 1'b0;
        init_rw            = 1'b0;
        bus_grant          = 1'b0;
        bus_data_in        = 1'b0;
        bus_data_in_valid  = 1'b0;
        bus_ack            = 1'b0;
        bus_split_ack      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) run_txn(vecs[k]);

        // Request withdrawn in REQ, with a grant arriving in the same cycle
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        check("req_asserted", bus_req, 1);
        init_req  = 1'b0;
        bus_grant = 1'b1;
        @(negedge clk);
        check("req_withdrawn", bus_req, 0);
        check("no_grant_withdraw", init_grant, 0);
        @(negedge clk);
        bus_grant = 1'b0;
        check("idle_bus_req", bus_req, 0);
        check("idle_grant", init_grant, 0);

        // Reset in the middle of the write-data phase, then a clean write
        arb_and_capture(1'b1, 16'h0012, 8'hC3);
        wait_until(W_DOV_HI, 40, "wdata_before_rst");
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        init_req = 1'b0;
        @(negedge clk);
        check("rst_mid_wdata", all_outputs(), 0);
        rst = 1'b0;
        @(negedge clk);
        run_txn('{1'b1, 16'h0012, 8'h5A, 8'h00, 1'b0, 2, 8'h5A, 0});

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("final_bus_req", bus_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
